lcd_window_sched: RTL and testbench
===================================

# lcd_window_sched

Frame-synchronous window scheduler for the RGB LCD pixel path. It sits between the LCD driver's pixel coordinate/request outputs and its `pixel_data` input. It shares the display among up to `NUM_WIN` rectangular solid-colour windows (product tiles, price box, status banner), with fixed priority. Window geometry and colour are written through a valid/ready config port into shadow registers, and a commit copies them to the active set only at a frame start, so the screen never tears.

## Interface
- `NUM_WIN`, 4, number of windows; index 0 has highest priority
- `POS_W`, 11, coordinate width; matches driver `pixel_xpos`/`pixel_ypos`
- `COLOR_W`, 24, RGB888 pixel width
- `lcd_pclk`  in  1  pixel clock; sole clock
- `rst`  in  1  synchronous, active-high reset
- `pixel_req`  in  1  driver data request for the current coordinate
- `pixel_xpos`  in  POS_W  requested column
- `pixel_ypos`  in  POS_W  requested row
- `frame_start`  in  1  one-cycle pulse at start of vertical blanking
- `bg_color`  in  COLOR_W  colour where no window hits
- `cfg_valid`  in  1  config write valid
- `cfg_ready`  out  1  config write accepted when high with `cfg_valid`
- `cfg_win`  in  clog2(NUM_WIN)  target window index
- `cfg_en`  in  1  window enable
- `cfg_x0`, `cfg_x1`, `cfg_y0`, `cfg_y1`  in  POS_W each  inclusive rectangle bounds
- `cfg_color`  in  COLOR_W  window fill colour
- `cfg_commit`  in  1  one-cycle request to apply the shadow set
- `commit_busy`  out  1  a commit is pending
- `commit_done`  out  1  one-cycle pulse when the active set has been updated
- `pixel_data`  out  COLOR_W  scheduled pixel colour
- `pixel_hit`  out  1  some window covers the pixel
- `pixel_win`  out  clog2(NUM_WIN)  winning window index; 0 when no hit

## Operation
- Config port: a write transfers when `cfg_valid && cfg_ready`. It loads the shadow entry `cfg_win` (en, x0, x1, y0, y1, color). `cfg_ready` is high only in IDLE.
- Commit FSM, states IDLE → PENDING → APPLY → IDLE.
  - IDLE: `cfg_commit` moves the FSM to PENDING.
  - PENDING: waits for `frame_start`, then moves to APPLY.
  - APPLY: lasts one cycle. It copies all shadow entries to active, pulses `commit_done`, and returns to IDLE.
- `commit_busy` is high in PENDING and APPLY.
- Simultaneous events:
  - A write and `cfg_commit` in the same IDLE cycle: the write is accepted and included in the commit.
  - `cfg_commit` and `frame_start` in the same IDLE cycle: the commit waits for the next `frame_start`.
  - `cfg_commit` while busy: ignored.
- Hit test per window: `en && x0<=x<=x1 && y0<=y<=y1`. The comparison is unsigned over the full POS_W. A window with x0>x1 or y0>y1 never hits.
- Priority: the lowest-index hitting window wins and supplies `pixel_data = color`. With no hit, `pixel_data = bg_color`, `pixel_hit=0`, `pixel_win=0`.
- If the delayed `pixel_req` is low, outputs are `pixel_data=0`, `pixel_hit=0`, `pixel_win=0`.
- Active registers change only in APPLY, so a frame is always rendered with one consistent set.
- Reset clears shadow and active entries to all-zero (disabled), discards any pending commit, and puts the FSM in IDLE.

## Timing
- Reset values: `cfg_ready=1` (first cycle after reset release), `commit_busy=0`, `commit_done=0`, `pixel_data=0`, `pixel_hit=0`, `pixel_win=0`.
- Pixel path latency is exactly 2 cycles, fully pipelined with one result per clock.
  - Stage 1 registers the per-window hit vector and the delayed `pixel_req`.
  - Stage 2 registers the priority-selected outputs.
- The driver's `pixel_req` lead is set to 2 cycles to match.
- APPLY occurs the cycle after `frame_start` is sampled in PENDING. `commit_done` is high in that cycle, and new windows affect outputs for requests sampled from the following cycle.
- `cfg_ready` drops the cycle after the commit is accepted and returns the cycle after APPLY.
- An active-high `rst` mid-PENDING yields `commit_done` never pulsing for that commit.
- `bg_color` is sampled in stage 1, alongside the coordinate.

## Structure
- The shared `lcd_pkg` holds:
  - the window entry typedef (en, x0, x1, y0, y1, color);
  - `POS_W`/`COLOR_W` defaults;
  - the commit FSM state enum.
- One sub-module, `lcd_win_hit`, contains one window's registered range comparison. It is instantiated `NUM_WIN` times.
- The shadow/active register banks, FSM and priority encoder stay in `lcd_window_sched`.

## Test plan
- **Reset then stream:** reset, stream pixels (0,0)…(799,479) with `bg_color=24'h202020` → every output 24'h202020, `pixel_hit=0`, 2-cycle latency.
- **Single window:** write win1 = (10,20)-(19,29), colour 24'hFF0000, then commit and pulse `frame_start` → `commit_done` one cycle later; pixel (10,20) → FF0000 with `pixel_win=1`; pixels (9,20) and (20,20) → background.
- **Overlap priority:** win0 = (0,0)-(15,15) blue, win2 = (8,8)-(31,31) green → (10,10) gives blue/win 0; (20,20) gives green/win 2.
- **Tear-free commit:** mid-frame, write new win1 geometry and commit → current frame keeps the old geometry, `cfg_ready=0` until APPLY, and the new geometry appears only after `frame_start`.
- **Edge cases:** commit and `frame_start` in the same cycle → applies only at the next `frame_start`. A window with x0=30, x1=5 never hits.
- **Reset mid-operation:** assert `rst` while PENDING → no `commit_done`, all windows disabled, output reverts to `bg_color`.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types for the LCD window scheduler:
// window entry layout, default widths and commit FSM states.
package lcd_pkg;

    localparam int LCD_POS_W   = 11;
    localparam int LCD_COLOR_W = 24;

    typedef struct packed {
        logic                   en;
        logic [LCD_POS_W-1:0]   x0;
        logic [LCD_POS_W-1:0]   x1;
        logic [LCD_POS_W-1:0]   y0;
        logic [LCD_POS_W-1:0]   y1;
        logic [LCD_COLOR_W-1:0] color;
    } win_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_APPLY = 2'd2
    } commit_st_t;

endpackage

// File: rtl/lcd_win_hit.sv
// Registered inclusive rectangle test for one window.
// An inverted rectangle (x0>x1 or y0>y1) can never satisfy both bounds.
module lcd_win_hit #(
    parameter int POS_W = 11
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [POS_W-1:0] x0_i,
    input  logic [POS_W-1:0] x1_i,
    input  logic [POS_W-1:0] y0_i,
    input  logic [POS_W-1:0] y1_i,
    input  logic [POS_W-1:0] x_i,
    input  logic [POS_W-1:0] y_i,
    output logic             hit_o
);

    logic hit_d;
    logic hit_q;

    always_comb begin
        hit_d = en_i
              && (x0_i <= x_i) && (x_i <= x1_i)
              && (y0_i <= y_i) && (y_i <= y1_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_q <= 1'b0;
        end else begin
            hit_q <= hit_d;
        end
    end

    assign hit_o = hit_q;

endmodule

// File: rtl/lcd_window_sched.sv
// Frame-synchronous fixed-priority window scheduler for the LCD pixel path.
// Shadow config is copied to the active bank only at a frame start.
module lcd_window_sched
    import lcd_pkg::*;
#(
    parameter int NUM_WIN = 4,
    parameter int POS_W   = LCD_POS_W,
    parameter int COLOR_W = LCD_COLOR_W,
    localparam int IDX_W  = $clog2(NUM_WIN)
) (
    input  logic               lcd_pclk,
    input  logic               rst,
    input  logic               pixel_req,
    input  logic [POS_W-1:0]   pixel_xpos,
    input  logic [POS_W-1:0]   pixel_ypos,
    input  logic               frame_start,
    input  logic [COLOR_W-1:0] bg_color,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [IDX_W-1:0]   cfg_win,
    input  logic               cfg_en,
    input  logic [POS_W-1:0]   cfg_x0,
    input  logic [POS_W-1:0]   cfg_x1,
    input  logic [POS_W-1:0]   cfg_y0,
    input  logic [POS_W-1:0]   cfg_y1,
    input  logic [COLOR_W-1:0] cfg_color,
    input  logic               cfg_commit,
    output logic               commit_busy,
    output logic               commit_done,
    output logic [COLOR_W-1:0] pixel_data,
    output logic               pixel_hit,
    output logic [IDX_W-1:0]   pixel_win
);

    commit_st_t st_q, st_d;
    win_t       sh_q  [NUM_WIN];
    win_t       act_q [NUM_WIN];
    win_t       wr_ent;

    logic [NUM_WIN-1:0] hit_vec;
    logic [COLOR_W-1:0] col1_q [NUM_WIN];
    logic               req1_q;
    logic [COLOR_W-1:0] bg1_q;

    logic [COLOR_W-1:0] sel_col;
    logic               sel_hit;
    logic [IDX_W-1:0]   sel_idx;
    logic [COLOR_W-1:0] data_q;
    logic               hit_q;
    logic [IDX_W-1:0]   win_q;

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            ST_IDLE:  if (cfg_commit) st_d = ST_PEND;
            ST_PEND:  if (frame_start) st_d = ST_APPLY;
            ST_APPLY: st_d = ST_IDLE;
            default:  st_d = ST_IDLE;
        endcase
    end

    assign cfg_ready   = (st_q == ST_IDLE);
    assign commit_busy = (st_q != ST_IDLE);
    assign commit_done = (st_q == ST_APPLY);

    always_comb begin
        wr_ent       = '0;
        wr_ent.en    = cfg_en;
        wr_ent.x0    = cfg_x0;
        wr_ent.x1    = cfg_x1;
        wr_ent.y0    = cfg_y0;
        wr_ent.y1    = cfg_y1;
        wr_ent.color = cfg_color;
    end

    always_ff @(posedge lcd_pclk) begin
        if (rst) begin
            st_q <= ST_IDLE;
            for (int i = 0; i < NUM_WIN; i++) begin
                sh_q[i]  <= '0;
                act_q[i] <= '0;
            end
        end else begin
            st_q <= st_d;
            if (cfg_valid && cfg_ready) begin
                sh_q[cfg_win] <= wr_ent;
            end
            if (st_q == ST_APPLY) begin
                act_q <= sh_q;
            end
        end
    end

    for (genvar g = 0; g < NUM_WIN; g++) begin : g_win
        lcd_win_hit #(
            .POS_W (POS_W)
        ) u_hit (
            .clk_i (lcd_pclk),
            .rst_i (rst),
            .en_i  (act_q[g].en),
            .x0_i  (act_q[g].x0),
            .x1_i  (act_q[g].x1),
            .y0_i  (act_q[g].y0),
            .y1_i  (act_q[g].y1),
            .x_i   (pixel_xpos),
            .y_i   (pixel_ypos),
            .hit_o (hit_vec[g])
        );
    end

    // Colours travel with the hit vector so an APPLY between stages
    // cannot mix geometry of one set with colour of the other.
    always_ff @(posedge lcd_pclk) begin
        if (rst) begin
            req1_q <= 1'b0;
            bg1_q  <= '0;
            for (int i = 0; i < NUM_WIN; i++) begin
                col1_q[i] <= '0;
            end
        end else begin
            req1_q <= pixel_req;
            bg1_q  <= bg_color;
            for (int i = 0; i < NUM_WIN; i++) begin
                col1_q[i] <= act_q[i].color;
            end
        end
    end

    always_comb begin
        sel_col = bg1_q;
        sel_hit = 1'b0;
        sel_idx = '0;
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                sel_col = col1_q[i];
                sel_hit = 1'b1;
                sel_idx = i[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge lcd_pclk) begin
        if (rst || !req1_q) begin
            data_q <= '0;
            hit_q  <= 1'b0;
            win_q  <= '0;
        end else begin
            data_q <= sel_col;
            hit_q  <= sel_hit;
            win_q  <= sel_idx;
        end
    end

    assign pixel_data = data_q;
    assign pixel_hit  = hit_q;
    assign pixel_win  = win_q;

endmodule

// File: tb/tb_lcd_window_sched.sv
// Directed bench for lcd_window_sched: commit timing, priority,
// tear-free update, inverted windows and reset during a pending commit.
module tb_lcd_window_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        pixel_req;
    logic [10:0] pixel_xpos;
    logic [10:0] pixel_ypos;
    logic        frame_start;
    logic [23:0] bg_color;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_win;
    logic        cfg_en;
    logic [10:0] cfg_x0;
    logic [10:0] cfg_x1;
    logic [10:0] cfg_y0;
    logic [10:0] cfg_y1;
    logic [23:0] cfg_color;
    logic        cfg_commit;
    logic        commit_busy;
    logic        commit_done;
    logic [23:0] pixel_data;
    logic        pixel_hit;
    logic [1:0]  pixel_win;

    int n_chk = 0;
    int n_err = 0;

    localparam logic [23:0] BG    = 24'h202020;
    localparam logic [23:0] RED   = 24'hFF0000;
    localparam logic [23:0] BLUE  = 24'h0000FF;
    localparam logic [23:0] GREEN = 24'h00FF00;
    localparam logic [23:0] WHITE = 24'hFFFFFF;

    always #5 clk = ~clk;

    lcd_window_sched dut (
        .lcd_pclk    (clk),
        .rst         (rst),
        .pixel_req   (pixel_req),
        .pixel_xpos  (pixel_xpos),
        .pixel_ypos  (pixel_ypos),
        .frame_start (frame_start),
        .bg_color    (bg_color),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_win     (cfg_win),
        .cfg_en      (cfg_en),
        .cfg_x0      (cfg_x0),
        .cfg_x1      (cfg_x1),
        .cfg_y0      (cfg_y0),
        .cfg_y1      (cfg_y1),
        .cfg_color   (cfg_color),
        .cfg_commit  (cfg_commit),
        .commit_busy (commit_busy),
        .commit_done (commit_done),
        .pixel_data  (pixel_data),
        .pixel_hit   (pixel_hit),
        .pixel_win   (pixel_win)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int x, input int y, input logic req,
                       input logic [23:0] ed, input logic eh,
                       input int ew);
        pixel_req  = req;
        pixel_xpos = 11'(x);
        pixel_ypos = 11'(y);
        tick();
        pixel_req = 1'b0;
        tick();
        chk($sformatf("data(%0d,%0d)", x, y), 32'(pixel_data), 32'(ed));
        chk($sformatf("hit(%0d,%0d)", x, y), 32'(pixel_hit), 32'(eh));
        chk($sformatf("win(%0d,%0d)", x, y), 32'(pixel_win), 32'(ew));
    endtask

    // Back-to-back pixels on one row; columns hx0..hx1 expect hcol/hwin.
    task automatic stream(input int y, input int xs, input int n,
                          input int hx0, input int hx1,
                          input logic [23:0] hcol, input int hwin);
        int xi;
        for (int i = 0; i < n + 2; i++) begin
            if (i >= 2) begin
                xi = xs + i - 2;
                if (xi >= hx0 && xi <= hx1) begin
                    chk("strm_data", 32'(pixel_data), 32'(hcol));
                    chk("strm_win", 32'(pixel_win), 32'(hwin));
                    chk("strm_hit", 32'(pixel_hit), 32'd1);
                end else begin
                    chk("strm_data", 32'(pixel_data), 32'(BG));
                    chk("strm_hit", 32'(pixel_hit), 32'd0);
                end
            end
            if (i < n) begin
                pixel_req  = 1'b1;
                pixel_xpos = 11'(xs + i);
                pixel_ypos = 11'(y);
            end else begin
                pixel_req = 1'b0;
            end
            tick();
        end
    endtask

    task automatic cfg_write(input int w, input logic en,
                             input int x0, input int x1,
                             input int y0, input int y1,
                             input logic [23:0] c, input logic cm);
        int n = 0;
        while (!cfg_ready && n < 50) begin
            tick();
            n++;
        end
        chk("cfg_ready_wait", 32'(cfg_ready), 32'd1);
        cfg_valid  = 1'b1;
        cfg_win    = 2'(w);
        cfg_en     = en;
        cfg_x0     = 11'(x0);
        cfg_x1     = 11'(x1);
        cfg_y0     = 11'(y0);
        cfg_y1     = 11'(y1);
        cfg_color  = c;
        cfg_commit = cm;
        tick();
        cfg_valid  = 1'b0;
        cfg_commit = 1'b0;
    endtask

    task automatic commit_pulse();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
    endtask

    task automatic frame_pulse();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        pixel_req   = 1'b0;
        pixel_xpos  = '0;
        pixel_ypos  = '0;
        frame_start = 1'b0;
        bg_color    = BG;
        cfg_valid   = 1'b0;
        cfg_win     = '0;
        cfg_en      = 1'b0;
        cfg_x0      = '0;
        cfg_x1      = '0;
        cfg_y0      = '0;
        cfg_y1      = '0;
        cfg_color   = '0;
        cfg_commit  = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        chk("rst_ready", 32'(cfg_ready), 32'd1);
        chk("rst_busy", 32'(commit_busy), 32'd0);
        chk("rst_done", 32'(commit_done), 32'd0);
        chk("rst_data", 32'(pixel_data), 32'd0);
        chk("rst_hit", 32'(pixel_hit), 32'd0);
        chk("rst_win", 32'(pixel_win), 32'd0);

        stream(0, 0, 800, 1, 0, BG, 0);
        stream(479, 0, 800, 1, 0, BG, 0);

        cfg_write(1, 1'b1, 10, 19, 20, 29, RED, 1'b0);
        commit_pulse();
        chk("c1_ready", 32'(cfg_ready), 32'd0);
        chk("c1_busy", 32'(commit_busy), 32'd1);
        chk("c1_done_pend", 32'(commit_done), 32'd0);
        frame_pulse();
        chk("c1_done", 32'(commit_done), 32'd1);
        tick();
        chk("c1_done_clr", 32'(commit_done), 32'd0);
        chk("c1_ready_back", 32'(cfg_ready), 32'd1);
        chk("c1_busy_clr", 32'(commit_busy), 32'd0);
        pix(10, 20, 1'b1, RED, 1'b1, 1);
        pix(9, 20, 1'b1, BG, 1'b0, 0);
        pix(20, 20, 1'b1, BG, 1'b0, 0);
        pix(19, 29, 1'b1, RED, 1'b1, 1);
        pix(19, 30, 1'b1, BG, 1'b0, 0);
        stream(20, 0, 40, 10, 19, RED, 1);

        cfg_write(0, 1'b1, 0, 15, 0, 15, BLUE, 1'b0);
        cfg_write(2, 1'b1, 8, 31, 8, 31, GREEN, 1'b1);
        chk("c2_busy", 32'(commit_busy), 32'd1);
        frame_pulse();
        chk("c2_done", 32'(commit_done), 32'd1);
        tick();
        pix(10, 10, 1'b1, BLUE, 1'b1, 0);
        pix(20, 20, 1'b1, GREEN, 1'b1, 2);
        pix(12, 22, 1'b1, RED, 1'b1, 1);
        pix(5, 5, 1'b1, BLUE, 1'b1, 0);

        cfg_write(1, 1'b1, 100, 109, 100, 109, WHITE, 1'b1);
        chk("c3_ready", 32'(cfg_ready), 32'd0);
        pix(12, 22, 1'b1, RED, 1'b1, 1);
        pix(100, 100, 1'b1, BG, 1'b0, 0);
        commit_pulse();
        chk("c3_ready_pend", 32'(cfg_ready), 32'd0);
        chk("c3_done_pend", 32'(commit_done), 32'd0);
        frame_pulse();
        chk("c3_done", 32'(commit_done), 32'd1);
        tick();
        chk("c3_busy_clr", 32'(commit_busy), 32'd0);
        tick();
        chk("c3_no_recommit", 32'(commit_busy), 32'd0);
        pix(100, 100, 1'b1, WHITE, 1'b1, 1);
        pix(12, 22, 1'b1, GREEN, 1'b1, 2);

        cfg_write(3, 1'b1, 30, 5, 0, 100, 24'h123456, 1'b0);
        cfg_commit  = 1'b1;
        frame_start = 1'b1;
        tick();
        cfg_commit  = 1'b0;
        frame_start = 1'b0;
        chk("c4_busy", 32'(commit_busy), 32'd1);
        chk("c4_done_early", 32'(commit_done), 32'd0);
        tick();
        chk("c4_still_pend", 32'(commit_busy), 32'd1);
        chk("c4_done_wait", 32'(commit_done), 32'd0);
        frame_pulse();
        chk("c4_done", 32'(commit_done), 32'd1);
        tick();
        pix(20, 50, 1'b1, BG, 1'b0, 0);
        pix(30, 50, 1'b1, BG, 1'b0, 0);
        pix(5, 50, 1'b1, BG, 1'b0, 0);
        pix(20, 20, 1'b1, GREEN, 1'b1, 2);
        pix(10, 10, 1'b0, 24'h0, 1'b0, 0);

        cfg_write(0, 1'b1, 0, 799, 0, 479, 24'hABCDEF, 1'b1);
        chk("c5_busy", 32'(commit_busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("c5_busy_clr", 32'(commit_busy), 32'd0);
        chk("c5_ready", 32'(cfg_ready), 32'd1);
        chk("c5_done", 32'(commit_done), 32'd0);
        frame_pulse();
        chk("c5_done_f1", 32'(commit_done), 32'd0);
        tick();
        chk("c5_done_f2", 32'(commit_done), 32'd0);
        pix(10, 10, 1'b1, BG, 1'b0, 0);
        pix(100, 100, 1'b1, BG, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
